// File: rtl/vga_scan_out_pkg.sv
// rtl/vga_scan_out_pkg.sv - VGA 640x480@60 timing defaults, colour constants and range helper
package vga_scan_out_pkg;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int CLK_DIV_DEF   = 2;

    localparam int COORD_W = 10;

    typedef logic [11:0] rgb444_t;

    localparam rgb444_t BLACK = 12'h000;

    // True when v lies in [lo, lo+len).
    function automatic logic in_range(input logic [COORD_W-1:0] v, input int lo, input int len);
        return (int'(v) >= lo) && (int'(v) < lo + len);
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// rtl/vga_timing_counter.sv - pixel clock divider, x/y scan counters, pix_tick and frame_start strobes
module vga_timing_counter
    import vga_scan_out_pkg::*;
#(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               pix_tick,
    output logic               frame_start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               tick_q;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        x_d   = x_q;
        y_d   = y_q;
        if (tick_q) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // tick_q mirrors (div == CLK_DIV-1) one cycle ahead so the strobe is a clean register that is low in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            div_q  <= div_d;
            tick_q <= (div_d == DIV_LAST);
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign pix_tick    = tick_q;
    assign frame_start = tick_q && (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/vga_scan_out.sv
// rtl/vga_scan_out.sv - VGA scan-out: timing, pixel/sync output registers, optional per-frame collision latch
// Optional feature macro: SCAN_COLLISION_LATCH_EN
module vga_scan_out
    import vga_scan_out_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int CLK_DIV   = CLK_DIV_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [11:0]        pixel_in,
    input  logic [31:0]        collision_num,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               active,
    output logic               pix_tick,
    output logic               frame_start,
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic [31:0]        frame_collisions
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    vga_timing_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .CLK_DIV (CLK_DIV)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .pix_tick    (pix_tick),
        .frame_start (frame_start)
    );

    assign active = in_range(x, 0, H_VISIBLE) && in_range(y, 0, V_VISIBLE);

    rgb444_t rgb_q;
    logic    hs_q, vs_q;

    // Colour and syncs share one tick of latency so the DAC sees them aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q <= BLACK;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else if (pix_tick) begin
            rgb_q <= active ? pixel_in : BLACK;
            hs_q  <= !in_range(x, H_VISIBLE + H_FRONT, H_SYNC);
            vs_q  <= !in_range(y, V_VISIBLE + V_FRONT, V_SYNC);
        end
    end

    assign vga_r  = rgb_q[11:8];
    assign vga_g  = rgb_q[7:4];
    assign vga_b  = rgb_q[3:0];
    assign vga_hs = hs_q;
    assign vga_vs = vs_q;

`ifdef SCAN_COLLISION_LATCH_EN
    logic [31:0] run_max_q, run_max_d, frame_coll_q;

    always_comb begin
        run_max_d = run_max_q;
        if (active && (collision_num > run_max_q))
            run_max_d = collision_num;
    end

    // The last pixel's contribution is folded in via run_max_d on the wrapping tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_max_q    <= '0;
            frame_coll_q <= '0;
        end else if (pix_tick) begin
            if (frame_start) begin
                frame_coll_q <= run_max_d;
                run_max_q    <= '0;
            end else begin
                run_max_q    <= run_max_d;
            end
        end
    end

    assign frame_collisions = frame_coll_q;
`else
    logic unused_collision;
    assign unused_collision = ^collision_num;
    assign frame_collisions = '0;
`endif

endmodule

// File: tb/tb_vga_scan_out.sv
// tb/tb_vga_scan_out.sv - self-checking bench for vga_scan_out on a reduced scan geometry
module tb_vga_scan_out;

    localparam int HV = 16, HF = 2, HS = 3, HB = 2;
    localparam int VV = 8,  VF = 1, VS = 2, VB = 2;
    localparam int D  = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME_CLKS = HT * VT * D;
`ifdef SCAN_COLLISION_LATCH_EN
    localparam int FC_HOT = 3;
`else
    localparam int FC_HOT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] pixel_in;
    logic [31:0] collision_num;
    logic [9:0]  x, y;
    logic        active, pix_tick, frame_start;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs;
    logic [31:0] frame_collisions;

    vga_scan_out #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .CLK_DIV   (D)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pixel_in         (pixel_in),
        .collision_num    (collision_num),
        .x                (x),
        .y                (y),
        .active           (active),
        .pix_tick         (pix_tick),
        .frame_start      (frame_start),
        .vga_r            (vga_r),
        .vga_g            (vga_g),
        .vga_b            (vga_b),
        .vga_hs           (vga_hs),
        .vga_vs           (vga_vs),
        .frame_collisions (frame_collisions)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tick_at(input int tx, input int ty, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2 * FRAME_CLKS; c++) begin
            if (int'(x) == tx && int'(y) == ty && pix_tick) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input bit hot);
        for (int c = 0; c < FRAME_CLKS + 4; c++) begin
            collision_num = hot ? ((x == 10'd4 && y == 10'd3) ? 32'd3 : 32'd1) : 32'd0;
            if (frame_start) begin
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        chk("frame_timeout", 0, 1);
    endtask

    typedef struct {
        int          tx;
        int          ty;
        logic [11:0] pix;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } vec_t;

    vec_t tbl[11];

    int          p, e, cnt;
    logic [11:0] exp_rgb;
    logic        exp_hs, exp_vs;
    logic [31:0] run, exp_fc;
    bit          ok;

    initial begin
        tbl[0]  = '{10, 5,  12'hF0A, 12'hF0A, 1'b1, 1'b1};
        tbl[1]  = '{3,  2,  12'h123, 12'h123, 1'b1, 1'b1};
        tbl[2]  = '{17, 2,  12'hFFF, 12'h000, 1'b1, 1'b1};
        tbl[3]  = '{18, 2,  12'hFFF, 12'h000, 1'b0, 1'b1};
        tbl[4]  = '{20, 2,  12'hABC, 12'h000, 1'b0, 1'b1};
        tbl[5]  = '{21, 2,  12'hABC, 12'h000, 1'b1, 1'b1};
        tbl[6]  = '{5,  9,  12'h777, 12'h000, 1'b1, 1'b0};
        tbl[7]  = '{5,  10, 12'h777, 12'h000, 1'b1, 1'b0};
        tbl[8]  = '{5,  11, 12'h777, 12'h000, 1'b1, 1'b1};
        tbl[9]  = '{15, 7,  12'h5A5, 12'h5A5, 1'b1, 1'b1};
        tbl[10] = '{0,  8,  12'h5A5, 12'h000, 1'b1, 1'b1};

        reset = 1'b1;
        pixel_in = 12'h000;
        collision_num = 32'd0;
        #1;
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("rst_hs", vga_hs, 1);
        chk("rst_vs", vga_vs, 1);
        chk("rst_tick", pix_tick, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_fc", frame_collisions, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reference model: position is (tick count) mod geometry, ticks occur every D-th clock.
        p = 0; e = 0; exp_rgb = 12'h000; exp_hs = 1'b1; exp_vs = 1'b1; run = 0; exp_fc = 0;
        for (int it = 0; it < 1500; it++) begin
            int   mx, my;
            logic tick, act, fs;
            mx   = p % HT;
            my   = (p / HT) % VT;
            tick = ((e + 1) % D) == 0;
            act  = (mx < HV) && (my < VV);
            fs   = tick && mx == HT - 1 && my == VT - 1;
            chk("m_x", x, mx);
            chk("m_y", y, my);
            chk("m_active", active, act);
            chk("m_tick", pix_tick, tick);
            chk("m_fs", frame_start, fs);
            chk("m_rgb", {vga_r, vga_g, vga_b}, exp_rgb);
            chk("m_hs", vga_hs, exp_hs);
            chk("m_vs", vga_vs, exp_vs);
            chk("m_fc", frame_collisions, exp_fc);
            pixel_in = 12'($urandom);
            collision_num = $urandom_range(0, 40);
            if (tick) begin
                exp_rgb = act ? pixel_in : 12'h000;
                exp_hs  = !(mx >= HV + HF && mx < HV + HF + HS);
                exp_vs  = !(my >= VV + VF && my < VV + VF + VS);
`ifdef SCAN_COLLISION_LATCH_EN
                if (fs) begin
                    exp_fc = (act && collision_num > run) ? collision_num : run;
                    run = 0;
                end else if (act && collision_num > run) begin
                    run = collision_num;
                end
`endif
                p++;
            end
            @(posedge clk);
            e++;
            @(negedge clk);
        end

        for (int i = 0; i < 11; i++) begin
            wait_tick_at(tbl[i].tx, tbl[i].ty, ok);
            if (!ok) chk("tbl_timeout", 0, 1);
            pixel_in = tbl[i].pix;
            @(negedge clk);
            chk("tbl_rgb", {vga_r, vga_g, vga_b}, tbl[i].rgb);
            chk("tbl_hs", vga_hs, tbl[i].hs);
            chk("tbl_vs", vga_vs, tbl[i].vs);
        end

        wait_tick_at(0, 1, ok);
        if (!ok) chk("hsw_timeout", 0, 1);
        cnt = 0;
        for (int c = 0; c < HT * D; c++) begin
            @(negedge clk);
            if (!vga_hs) cnt++;
        end
        chk("hs_width_clks", cnt, HS * D);

        wait_tick_at(HT - 1, VT - 1, ok);
        if (!ok) chk("wrap_timeout", 0, 1);
        chk("wrap_fs", frame_start, 1);
        @(negedge clk);
        chk("wrap_x", x, 0);
        chk("wrap_y", y, 0);
        chk("wrap_fs_off", frame_start, 0);
        cnt = 0;
        for (int c = 0; c < FRAME_CLKS; c++) begin
            if (frame_start) cnt++;
            @(negedge clk);
        end
        chk("fs_per_frame", cnt, 1);

        wait_tick_at(HT - 1, VT - 1, ok);
        if (!ok) chk("coll_timeout", 0, 1);
        @(negedge clk);
        run_frame(1'b1);
        chk("fc_hot", frame_collisions, FC_HOT);
        run_frame(1'b0);
        chk("fc_zero", frame_collisions, 0);

        pixel_in = 12'hFFF;
        wait_tick_at(10, 5, ok);
        if (!ok) chk("mid_timeout", 0, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_x", x, 0);
        chk("mid_y", y, 0);
        chk("mid_rgb", {vga_r, vga_g, vga_b}, 0);
        chk("mid_hs", vga_hs, 1);
        chk("mid_vs", vga_vs, 1);
        chk("mid_tick", pix_tick, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("restart_x0", x, 0);
        @(negedge clk);
        chk("restart_x1", x, 1);
        chk("restart_y", y, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
